sram512x8_arbiter: RTL and testbench



---
 rtl/sram512x8_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram512x8_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram512x8_arbiter.sv
// rtl/sram512x8_arbiter.sv - two-port req/gnt arbiter owning an SRAM1RW512x8 macro, with post-reset clear
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN (port 0 always wins; default is round-robin)
module sram512x8_arbiter #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00,
    parameter bit                INIT_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              init_done,
    output logic              sram_ce,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              owner_q;
    logic              p0_rvalid_q;
    logic              p1_rvalid_q;
    logic              init_done_q;

    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic              rr_last_q;
`endif

    // The macro is clocked directly from the arbiter clock
    assign sram_ce   = clk;
    assign rdata     = rdata_q;
    assign init_done = init_done_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;

    // Grant one requester while idle; gated by rst_n so no grant shows during reset
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            p0_gnt = p0_req;
            p1_gnt = p1_req & ~p0_req;
`else
            if (p0_req && p1_req) begin
                p0_gnt = rr_last_q;
                p1_gnt = ~rr_last_q;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
`endif
        end
    end

    // Pick the winning port's command fields for registration
    always_comb begin
        sel_we_d    = p0_we;
        sel_addr_d  = p0_addr;
        sel_wdata_d = p0_wdata;
        if (p1_gnt) begin
            sel_we_d    = p1_we;
            sel_addr_d  = p1_addr;
            sel_wdata_d = p1_wdata;
        end
    end

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // Remember the last winner so the next tie goes to the other port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else if (p0_gnt || p1_gnt) begin
            rr_last_q <= p1_gnt;
        end
    end
`endif

    // Main sequencer: clear the array, then run one access at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    init_done_q <= 1'b1;
                    if (p0_gnt || p1_gnt) begin
                        owner_q <= p1_gnt;
                        we_q    <= sel_we_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= we_q ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rdata_q     <= sram_o;
                    p0_rvalid_q <= ~owner_q;
                    p1_rvalid_q <= owner_q;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Macro pins follow the registered state; the clear writes start in the first cycle after reset release
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_oeb = 1'b1;
        sram_a   = addr_q;
        sram_i   = wdata_q;
        case (state_q)
            ST_INIT: begin
                if (rst_n) begin
                    sram_csb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = cnt_q;
                    sram_i   = INIT_VALUE;
                end
            end
            ST_ISSUE: begin
                sram_csb = 1'b0;
                sram_web = ~we_q;
                sram_oeb = we_q;
            end
            ST_CAPTURE: begin
                sram_oeb = 1'b0;
            end
            default: begin
                sram_csb = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram512x8_arbiter.sv
// tb/tb_sram512x8_arbiter.sv - self-checking bench for sram512x8_arbiter
`timescale 1ns/1ps
module tb_sram512x8_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [8:0] p0_addr;
    logic [7:0] p0_wdata;
    logic       p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [8:0] p1_addr;
    logic [7:0] p1_wdata;
    logic [7:0] rdata;
    logic       init_done, sram_ce, sram_csb, sram_web, sram_oeb;
    logic [8:0] sram_a;
    logic [7:0] sram_i, sram_o;

    always #5 clk = ~clk;

    sram512x8_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .init_done(init_done),
        .sram_ce(sram_ce), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
    );

    // Behavioural macro: samples pins on the rising clock, drives data only while oeb is low
    logic [7:0] mem [512];
    logic [7:0] dout;
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] = sram_i;
            else           dout <= mem[sram_a];
        end
    end
    assign sram_o = sram_oeb ? 8'h5A : dout;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " gnt"}, {p1_gnt, p0_gnt}, 2'b00);
        chk({tag, " rvalid"}, {p1_rvalid, p0_rvalid}, 2'b00);
        chk({tag, " rdata"}, rdata, 8'h00);
        chk({tag, " init_done"}, init_done, 1'b0);
        chk({tag, " csb/web/oeb"}, {sram_csb, sram_web, sram_oeb}, 3'b111);
        chk({tag, " sram_a"}, sram_a, 9'h000);
        chk({tag, " sram_i"}, sram_i, 8'h00);
    endtask

    task automatic prefill_mem();
        for (int i = 0; i < 512; i++) mem[i] = i[7:0] ^ 8'hC7;
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        chk_reset_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Follows the clear from reset release; optionally stops once a given address is being written
    task automatic run_init(input int abort_a, output int edges, output int writes,
                            output int order_err, output int stray, output bit aborted);
        edges = 0; writes = 0; order_err = 0; stray = 0; aborted = 1'b0;
        while (edges < 600) begin
            @(negedge clk);
            if (p0_rvalid || p1_rvalid || p0_gnt || p1_gnt) stray++;
            if (init_done) break;
            if (!sram_csb && !sram_web) begin
                if (sram_a != writes[8:0] || sram_i != 8'h00) order_err++;
                writes++;
                if (abort_a >= 0 && int'(sram_a) == abort_a) begin
                    aborted = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic init_and_check(input string tag);
        int e, w, o, s, bad;
        bit a;
        run_init(-1, e, w, o, s, a);
        chk({tag, " init edges"}, e, 512);
        chk({tag, " init writes"}, w, 512);
        chk({tag, " init order"}, o, 0);
        chk({tag, " stray gnt/rvalid"}, s, 0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] != 8'h00) bad++;
        chk({tag, " nonzero words"}, bad, 0);
    endtask

    task automatic do_access(input bit port, input bit we, input logic [8:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd, input string name);
        int waits;
        waits = 0;
        @(posedge clk); #1;
        if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
        @(negedge clk);
        while (!(port ? p1_gnt : p0_gnt) && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        chk({name, " gnt wait"}, waits, 0);
        chk({name, " other gnt"}, port ? p0_gnt : p1_gnt, 1'b0);
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk({name, " rvalid T+1"}, {p1_rvalid, p0_rvalid}, 2'b00);
            @(negedge clk);
            chk({name, " rvalid T+2"}, {p1_rvalid, p0_rvalid}, 2'b00);
            @(negedge clk);
            chk({name, " rvalid T+3"}, {p1_rvalid, p0_rvalid}, port ? 2'b10 : 2'b01);
            chk({name, " rdata"}, rdata, exp_rd);
        end
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        int         t;
        bit         port;
        logic [7:0] d;
    } exp_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[9];
        exp_t       exp_q[$];
        logic [7:0] ref_mem [512];
        int         e, w, o, s, ngr, both, p0g, next_free;
        bit         a, last, win, exp_port, g0_prev, g1_prev, mwe;
        logic [1:0] e_g, e_rv;
        logic [7:0] e_rd, mwd;
        logic [8:0] maddr;

        vecs[0] = '{1'b0, 1'b0, 9'h1FF, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 9'h1FE, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 9'h0A5, 8'h3C, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 9'h0A5, 8'h00, 8'h3C};
        vecs[4] = '{1'b1, 1'b1, 9'h000, 8'h81, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 9'h000, 8'h00, 8'h81};
        vecs[6] = '{1'b0, 1'b0, 9'h000, 8'h00, 8'h81};
        vecs[7] = '{1'b1, 1'b1, 9'h0A5, 8'hC3, 8'h00};
        vecs[8] = '{1'b0, 1'b0, 9'h0A5, 8'h00, 8'hC3};

        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        prefill_mem();

        // Reset values, full clear of a dirty array, ce follows clk
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t1 reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t1 sram_ce high", sram_ce, 1'b1);
        init_and_check("t1");
        chk("t1 sram_ce low", sram_ce, 1'b0);

        // Single-port accesses, including write then read two cycles later
        for (int i = 0; i < 9; i++)
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                      $sformatf("vec%0d", i));

        // p1 write while p0 pulses req during ISSUE only
        p0g = 0;
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h1FF; p1_wdata = 8'hFF;
        @(negedge clk);
        chk("t5 p1 gnt", p1_gnt, 1'b1);
        p0g += int'(p0_gnt);
        @(posedge clk); #1;
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h1FF; p0_wdata = 8'h11;
        @(negedge clk);
        chk("t5 issue pins", {sram_csb, sram_web, sram_a}, {2'b00, 9'h1FF});
        p0g += int'(p0_gnt);
        @(posedge clk); #1;
        p0_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            p0g += int'(p0_gnt);
        end
        chk("t5 p0 grants", p0g, 0);
        chk("t5 mem[1FF]", mem[9'h1FF], 8'hFF);

        // Reset during the CAPTURE cycle of a read
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h0A5;
        @(negedge clk);
        chk("t4 gnt", p0_gnt, 1'b1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        @(posedge clk); #1;
        chk("t4 in capture", {sram_csb, sram_oeb}, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t4 reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        init_and_check("t4");

        // Reset in the middle of the clear
        prefill_mem();
        apply_reset("t6a reset");
        run_init(256, e, w, o, s, a);
        chk("t6 reached 0x100", a, 1'b1);
        chk("t6 writes before abort", w, 257);
        chk("t6 order before abort", o, 0);
        apply_reset("t6b reset");
        init_and_check("t6");

        // Both ports reading continuously
        apply_reset("t3 reset");
        init_and_check("t3");
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h010;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h020;
        ngr = 0; both = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (p0_gnt && p1_gnt) both++;
            else if (p0_gnt || p1_gnt) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                exp_port = 1'b0;
`else
                exp_port = ngr[0];
`endif
                chk($sformatf("t3 grant %0d port", ngr), p1_gnt, exp_port);
                ngr++;
            end
        end
        chk("t3 double grant", both, 0);
        chk("t3 grant count", ngr, 10);
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (4) @(posedge clk);

        // Random traffic against a transaction-level model
        apply_reset("rnd reset");
        init_and_check("rnd");
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        last = 1'b1; next_free = 0; g0_prev = 1'b0; g1_prev = 1'b0;
        for (int k = 0; k < 2006; k++) begin
            @(posedge clk); #1;
            if (g0_prev) p0_req = 1'b0;
            if (g1_prev) p1_req = 1'b0;
            if (!p0_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    p0_req = 1'b1; p0_we = 1'($urandom_range(1, 0));
                    p0_addr = 9'($urandom_range(7, 0)) | ($urandom_range(1, 0) == 1 ? 9'h1F8 : 9'h000);
                    p0_wdata = 8'($urandom);
                end
            end else if ($urandom_range(15, 0) == 0) p0_req = 1'b0;
            if (!p1_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    p1_req = 1'b1; p1_we = 1'($urandom_range(1, 0));
                    p1_addr = 9'($urandom_range(7, 0)) | ($urandom_range(1, 0) == 1 ? 9'h1F8 : 9'h000);
                    p1_wdata = 8'($urandom);
                end
            end else if ($urandom_range(15, 0) == 0) p1_req = 1'b0;
            if (k >= 2000) begin
                p0_req = 1'b0; p1_req = 1'b0;
            end
            @(negedge clk);
            e_rv = 2'b00; e_rd = 8'h00;
            if (exp_q.size() > 0 && exp_q[0].t == k) begin
                e_rv = exp_q[0].port ? 2'b10 : 2'b01;
                e_rd = exp_q[0].d;
                void'(exp_q.pop_front());
            end
            e_g = 2'b00;
            if (k >= next_free && (p0_req || p1_req)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                win = !p0_req;
`else
                win = (p0_req && p1_req) ? ~last : p1_req;
`endif
                last = win;
                e_g = win ? 2'b10 : 2'b01;
                mwe = win ? p1_we : p0_we;
                maddr = win ? p1_addr : p0_addr;
                mwd = win ? p1_wdata : p0_wdata;
                if (mwe) begin
                    ref_mem[maddr] = mwd;
                    next_free = k + 2;
                end else begin
                    exp_q.push_back('{k + 3, win, ref_mem[maddr]});
                    next_free = k + 3;
                end
            end
            chk($sformatf("rnd gnt c%0d", k), {p1_gnt, p0_gnt}, e_g);
            chk($sformatf("rnd rvalid c%0d", k), {p1_rvalid, p0_rvalid}, e_rv);
            if (e_rv != 2'b00) chk($sformatf("rnd rdata c%0d", k), rdata, e_rd);
            g0_prev = e_g[0];
            g1_prev = e_g[1];
        end
        chk("rnd pending reads", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
